// File: rtl/gray_seq_monitor_pkg.sv
// gray_seq_monitor_pkg: shared FSM state encoding and default parameter values
// for the Gray-code sequence monitor and its bus interface.
package gray_seq_monitor_pkg;

    localparam int unsigned N_DEFAULT        = 3;
    localparam int unsigned ERR_W_DEFAULT    = 8;
    localparam int unsigned LOCK_CNT_DEFAULT = 4;

    // Run counter is wide enough for the largest legal LOCK_CNT (255)
    localparam int unsigned RUN_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

endpackage

// File: rtl/gray_seq_monitor_if.sv
// gray_seq_monitor_if: sample bus from the Gray converter plus the monitor's
// check results.
//   master: drives g_valid/g/dir, observes the results (converter side / bench)
//   slave : receives samples, drives b_out/b_valid/step_ok/step_err/err_cnt/
//           locked/wrap_pulse (the monitor)
interface gray_seq_monitor_if
    import gray_seq_monitor_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned ERR_W = ERR_W_DEFAULT
);
    logic             g_valid;
    logic [N-1:0]     g;
    logic             dir;
    logic [N-1:0]     b_out;
    logic             b_valid;
    logic             step_ok;
    logic             step_err;
    logic [ERR_W-1:0] err_cnt;
    logic             locked;
    logic             wrap_pulse;

    modport master (
        output g_valid, g, dir,
        input  b_out, b_valid, step_ok, step_err, err_cnt, locked, wrap_pulse
    );

    modport slave (
        input  g_valid, g, dir,
        output b_out, b_valid, step_ok, step_err, err_cnt, locked, wrap_pulse
    );
endinterface

// File: rtl/gray_seq_monitor_gray2bin_n.sv
// gray2bin_n: combinational N-bit Gray -> binary decode.
//   g : Gray code in
//   b : binary out, b[i] = XOR of g[N-1:i]
module gray2bin_n #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] g,
    output logic [N-1:0] b
);
    // Shifting right by i leaves exactly g[N-1:i]; its XOR reduction is b[i]
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign b[i] = ^(g >> i);
    end
endmodule

// File: rtl/gray_seq_monitor.sv
// gray_seq_monitor: decodes each sampled Gray word and checks that successive
// codes step by +1 (dir=1) or -1 (dir=0) modulo 2^N.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : synchronous soft clear, same effect as reset
//   bus        : slave side of gray_seq_monitor_if (sample in, results out)
// All results are registered and reflect the sample taken one edge earlier.
module gray_seq_monitor
    import gray_seq_monitor_pkg::*;
#(
    parameter int unsigned N        = N_DEFAULT,
    parameter int unsigned ERR_W    = ERR_W_DEFAULT,
    parameter int unsigned LOCK_CNT = LOCK_CNT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    gray_seq_monitor_if.slave   bus
);

    state_t           state;
    logic [N-1:0]     b;
    logic [N-1:0]     prev_g;
    logic [N-1:0]     prev_b;
    logic [RUN_W-1:0] ok_run;

    logic [N-1:0]     exp_b_c;
    logic [RUN_W-1:0] run_inc_c;
    logic             wrap_c;

    gray2bin_n #(.N(N)) u_dec (
        .g (bus.g),
        .b (b)
    );

    // Expected next value and wrap condition from the previous accepted sample
    always_comb begin
        exp_b_c   = bus.dir ? prev_b + N'(1) : prev_b - N'(1);
        wrap_c    = bus.dir ? (prev_b == '1) : (prev_b == '0);
        run_inc_c = (ok_run < RUN_W'(LOCK_CNT)) ? ok_run + RUN_W'(1) : ok_run;
    end

    // FSM, counters and output registers
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state          <= ST_IDLE;
            prev_g         <= '0;
            prev_b         <= '0;
            ok_run         <= '0;
            bus.b_out      <= '0;
            bus.b_valid    <= 1'b0;
            bus.step_ok    <= 1'b0;
            bus.step_err   <= 1'b0;
            bus.err_cnt    <= '0;
            bus.locked     <= 1'b0;
            bus.wrap_pulse <= 1'b0;
        end else begin
            bus.b_valid    <= 1'b0;
            bus.step_ok    <= 1'b0;
            bus.step_err   <= 1'b0;
            bus.wrap_pulse <= 1'b0;
            if (bus.g_valid) begin
                case (state)
                    ST_IDLE: begin
                        // First sample only seeds the history
                        prev_g      <= bus.g;
                        prev_b      <= b;
                        bus.b_out   <= b;
                        bus.b_valid <= 1'b1;
                        state       <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        // An unchanged code is a stall, not a step
                        if (bus.g != prev_g) begin
                            prev_g      <= bus.g;
                            prev_b      <= b;
                            bus.b_out   <= b;
                            bus.b_valid <= 1'b1;
                            if (b == exp_b_c) begin
                                bus.step_ok    <= 1'b1;
                                bus.wrap_pulse <= wrap_c;
                                ok_run         <= run_inc_c;
                                if (run_inc_c == RUN_W'(LOCK_CNT)) begin
                                    bus.locked <= 1'b1;
                                end
                            end else begin
                                bus.step_err <= 1'b1;
                                ok_run       <= '0;
                                bus.locked   <= 1'b0;
                                if (bus.err_cnt != '1) begin
                                    bus.err_cnt <= bus.err_cnt + ERR_W'(1);
                                end
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_seq_monitor.sv
// tb_gray_seq_monitor: directed plus randomized stimulus for gray_seq_monitor,
// checked each cycle against a table-driven behavioural model.
module tb_gray_seq_monitor;

    localparam int unsigned N        = 3;
    localparam int unsigned ERR_W    = 8;
    localparam int unsigned LOCK_CNT = 4;
    localparam int          MODV     = 1 << N;
    localparam int          ERR_MAX  = (1 << ERR_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;

    always #5 clk = ~clk;

    gray_seq_monitor_if #(.N(N), .ERR_W(ERR_W)) bus ();

    gray_seq_monitor #(.N(N), .ERR_W(ERR_W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus.slave)
    );

    int total  = 0;
    int passed = 0;

    // Gray encode table and its inverse
    int enc [MODV];
    int dec [MODV];

    // Reference model state
    bit m_track;
    int m_prev_g, m_prev_b, m_b_out, m_err, m_run;
    bit m_locked, m_bv, m_ok, m_se, m_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic model(input bit r, input bit c, input bit v, input int gg, input bit d);
        int bb, expb;
        m_bv = 0; m_ok = 0; m_se = 0; m_wrap = 0;
        if (r || c) begin
            m_track = 0; m_prev_g = 0; m_prev_b = 0; m_b_out = 0;
            m_err = 0; m_run = 0; m_locked = 0;
        end else if (v) begin
            bb = dec[gg];
            if (!m_track) begin
                m_track = 1; m_prev_g = gg; m_prev_b = bb; m_b_out = bb; m_bv = 1;
            end else if (gg != m_prev_g) begin
                expb = (m_prev_b + (d ? 1 : MODV - 1)) % MODV;
                if (bb == expb) begin
                    m_ok   = 1;
                    m_wrap = d ? (m_prev_b == MODV - 1) : (m_prev_b == 0);
                    if (m_run < LOCK_CNT) m_run++;
                    if (m_run == LOCK_CNT) m_locked = 1;
                end else begin
                    m_se = 1; m_run = 0; m_locked = 0;
                    if (m_err < ERR_MAX) m_err++;
                end
                m_prev_g = gg; m_prev_b = bb; m_b_out = bb; m_bv = 1;
            end
        end
    endtask

    // Apply one cycle of inputs, then compare every output against the model
    task automatic drive(input bit r, input bit c, input bit v, input int gg, input bit d);
        rst_n       = ~r;
        clear       = c;
        bus.g_valid = v;
        bus.g       = N'(gg);
        bus.dir     = d;
        @(posedge clk);
        #1;
        model(r, c, v, gg, d);
        chk("b_out",      32'(bus.b_out),      32'(m_b_out));
        chk("b_valid",    32'(bus.b_valid),    32'(m_bv));
        chk("step_ok",    32'(bus.step_ok),    32'(m_ok));
        chk("step_err",   32'(bus.step_err),   32'(m_se));
        chk("err_cnt",    32'(bus.err_cnt),    32'(m_err));
        chk("locked",     32'(bus.locked),     32'(m_locked));
        chk("wrap_pulse", 32'(bus.wrap_pulse), 32'(m_wrap));
    endtask

    initial begin
        bit d;
        int r;
        int gg;

        for (int i = 0; i < MODV; i++) begin
            enc[i] = i ^ (i >> 1);
            dec[enc[i]] = i;
        end
        m_track = 0; m_prev_g = 0; m_prev_b = 0; m_b_out = 0;
        m_err = 0; m_run = 0; m_locked = 0;

        // Reset
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 1, 5, 1);

        // Full up sequence with wrap 100 -> 000
        for (int i = 0; i <= MODV; i++) drive(0, 0, 1, enc[i % MODV], 1);

        // Down sequence from 0 after clear: wrap on 000 -> 100
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, enc[0], 0);
        for (int i = MODV - 1; i >= MODV - 3; i--) drive(0, 0, 1, enc[i], 0);

        // Error and resync: 0,1,2 then 4 (illegal), then 5 (legal)
        drive(0, 1, 0, 0, 1);
        for (int i = 0; i <= 2; i++) drive(0, 0, 1, enc[i], 1);
        drive(0, 0, 1, enc[4], 1);
        drive(0, 0, 1, enc[5], 1);

        // Stall and gaps
        drive(0, 1, 0, 0, 1);
        drive(0, 0, 1, enc[0], 1);
        drive(0, 0, 1, enc[1], 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, enc[2], 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, enc[6], 0);
        drive(0, 0, 1, enc[3], 1);

        // Three errors, reset mid-track, then clear alongside a valid sample
        drive(0, 0, 1, enc[0], 1);
        drive(0, 0, 1, enc[2], 1);
        drive(0, 0, 1, enc[0], 1);
        drive(1, 0, 1, enc[1], 1);
        drive(0, 1, 1, enc[2], 1);
        drive(0, 0, 1, enc[3], 1);

        // Single-bit change in the wrong direction is an error
        drive(0, 0, 1, enc[2], 1);

        // Error counter saturation: 0 <-> 2 is never a legal step
        for (int i = 0; i < ERR_MAX + 10; i++) drive(0, 0, 1, (i % 2 == 0) ? enc[0] : enc[2], i[0]);

        // Randomized traffic
        drive(0, 1, 0, 0, 1);
        d = 1;
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 9) == 0) d = ~d;
            gg = enc[(m_prev_b + (d ? 1 : MODV - 1)) % MODV];
            if (r < 1)       drive(1, 0, 1, gg, d);
            else if (r < 3)  drive(0, 1, 1, gg, d);
            else if (r < 13) drive(0, 0, 0, int'($urandom_range(0, MODV - 1)), d);
            else if (r < 23) drive(0, 0, 1, m_prev_g, d);
            else if (r < 38) drive(0, 0, 1, int'($urandom_range(0, MODV - 1)), d);
            else             drive(0, 0, 1, gg, d);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
